// File: rtl/hash_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hash_pkg
// Purpose  : Shared widths, nibble/word types and a counter-width helper for
//            the hash nibble link blocks.
// Revision : 1.0  initial release
// ============================================================================
package hash_pkg;

  localparam int NIB_W         = 4;
  localparam int WORD_W        = 32;
  localparam int NIBS_PER_WORD = 8;
  localparam int NIB_CNT_W     = $clog2(NIBS_PER_WORD);

  typedef logic [NIB_W-1:0]     nibble_t;
  typedef logic [WORD_W-1:0]    hash_word_t;
  typedef logic [NIB_CNT_W-1:0] nib_cnt_t;

  // Counter width that never collapses to zero bits for a single-entry count.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/nibble_word_reg.sv
`default_nettype none
// ============================================================================
// Module   : nibble_word_reg
// Purpose  : Single-entry valid/ready output register for assembled words.
//            Holds data/last stable while stalled; a load in the same cycle
//            as a drain replaces the old word without a bubble.
// Revision : 1.0  initial release
// ============================================================================
module nibble_word_reg
  import hash_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load_i,
  input  hash_word_t data_i,
  input  logic       last_i,
  input  logic       ready_i,
  output logic       valid_o,
  output hash_word_t data_o,
  output logic       last_o
);

  logic       valid_q;
  hash_word_t data_q;
  logic       last_q;

  // Load wins over drain so a simultaneous drain+load keeps valid asserted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      last_q  <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
      last_q  <= last_i;
    end else if (ready_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;
  assign last_o  = last_q;

endmodule
`default_nettype wire

// File: rtl/nibble_assembler.sv
`default_nettype none
// ============================================================================
// Module   : nibble_assembler
// Purpose  : Rebuilds 32-bit words from a least-significant-nibble-first
//            stream and frames NWORDS words per digest, flagging framing
//            violations with a one-cycle frame_err pulse.
// Revision : 1.0  initial release
// ============================================================================
module nibble_assembler
  import hash_pkg::*;
#(
  parameter int NWORDS = 8,
  parameter int CNT_W  = cnt_width(NWORDS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              nib_valid,
  output logic              nib_ready,
  input  logic [NIB_W-1:0]  nib_data,
  input  logic              nib_last,
  output logic              word_valid,
  input  logic              word_ready,
  output logic [WORD_W-1:0] word_data,
  output logic              word_last,
  output logic              frame_err
);

  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(NWORDS - 1);
  localparam nib_cnt_t         LAST_NIB  = nib_cnt_t'(NIBS_PER_WORD - 1);
  // Only the first seven nibbles need storing; the eighth is taken straight
  // from the input when the word is loaded into the output register.
  localparam int               SR_W      = WORD_W - NIB_W;

  nib_cnt_t         nib_cnt_q, nib_cnt_d;
  logic [CNT_W-1:0] word_cnt_q, word_cnt_d;
  logic [SR_W-1:0]  sr_q, sr_d;
  logic             frame_err_q, frame_err_d;

  logic       accept;
  logic       at_last_nib;
  logic       at_last_word;
  logic       at_final;
  logic       word_load;
  logic       load_last;
  hash_word_t load_data;

  assign at_last_nib  = (nib_cnt_q == LAST_NIB);
  assign at_last_word = (word_cnt_q == LAST_WORD);
  assign at_final     = at_last_nib && at_last_word;

  // The 8th nibble may only enter when the output slot is free or draining.
  assign nib_ready = !at_last_nib || !word_valid || word_ready;
  assign accept    = nib_valid && nib_ready;

  assign word_load = accept && at_last_nib;
  assign load_data = {nib_data, sr_q};
  // Any word that ends the frame, correctly or not, is marked last.
  assign load_last = at_last_word || nib_last;

  // Next-state for counters, nibble shift register and framing error flag.
  always_comb begin
    nib_cnt_d   = nib_cnt_q;
    word_cnt_d  = word_cnt_q;
    sr_d        = sr_q;
    frame_err_d = 1'b0;
    if (accept) begin
      sr_d        = {nib_data, sr_q[SR_W-1:NIB_W]};
      frame_err_d = nib_last ^ at_final;
      if (nib_last || at_final) begin
        nib_cnt_d  = '0;
        word_cnt_d = '0;
      end else if (at_last_nib) begin
        nib_cnt_d  = '0;
        word_cnt_d = word_cnt_q + CNT_W'(1);
      end else begin
        nib_cnt_d  = nib_cnt_q + nib_cnt_t'(1);
      end
    end
  end

  // State registers with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      nib_cnt_q   <= '0;
      word_cnt_q  <= '0;
      sr_q        <= '0;
      frame_err_q <= 1'b0;
    end else begin
      nib_cnt_q   <= nib_cnt_d;
      word_cnt_q  <= word_cnt_d;
      sr_q        <= sr_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign frame_err = frame_err_q;

  nibble_word_reg u_word_reg (
    .clk     (clk),
    .rst_n   (rst_n),
    .load_i  (word_load),
    .data_i  (load_data),
    .last_i  (load_last),
    .ready_i (word_ready),
    .valid_o (word_valid),
    .data_o  (word_data),
    .last_o  (word_last)
  );

endmodule
`default_nettype wire

// File: tb/tb_nibble_assembler.sv
`default_nettype none
// ============================================================================
// Module   : tb_nibble_assembler
// Purpose  : Self-checking bench for nibble_assembler with NWORDS=2 and
//            NWORDS=1 instances sharing one stimulus stream.
// Revision : 1.0  initial release
// ============================================================================
module tb_nibble_assembler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        nib_valid, nib_last, word_ready;
  logic [3:0]  nib_data;

  logic        rdy_a, val_a, last_a, err_a;
  logic [31:0] data_a;
  logic        rdy_b, val_b, last_b, err_b;
  logic [31:0] data_b;

  logic        sel;       // 0: watch NWORDS=2 instance, 1: NWORDS=1 instance
  logic        rdy_s, val_s, last_s, err_s;
  logic [31:0] data_s;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  nibble_assembler #(.NWORDS(2)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .nib_valid(nib_valid), .nib_ready(rdy_a),
    .nib_data(nib_data), .nib_last(nib_last), .word_valid(val_a),
    .word_ready(word_ready), .word_data(data_a), .word_last(last_a),
    .frame_err(err_a)
  );

  nibble_assembler #(.NWORDS(1)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .nib_valid(nib_valid), .nib_ready(rdy_b),
    .nib_data(nib_data), .nib_last(nib_last), .word_valid(val_b),
    .word_ready(word_ready), .word_data(data_b), .word_last(last_b),
    .frame_err(err_b)
  );

  always_comb begin
    rdy_s  = sel ? rdy_b  : rdy_a;
    val_s  = sel ? val_b  : val_a;
    data_s = sel ? data_b : data_a;
    last_s = sel ? last_b : last_a;
    err_s  = sel ? err_b  : err_a;
  end

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] data;
    logic        last;
  } exp_t;

  exp_t       exp_q[$];
  logic [3:0] m_nibs[$];
  int         m_widx;
  logic       err_pend;
  int         stall_cnt;
  logic       acc_d;

  function automatic int nw();
    return sel ? 1 : 2;
  endfunction

  task automatic model_reset();
    exp_q.delete();
    m_nibs.delete();
    m_widx   = 0;
    err_pend = 1'b0;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s @%0t: got %h, expected %h", nm, $time, act, req);
    end
  endtask

  // One cycle: drive inputs at the falling edge, check, advance the model.
  task automatic step(input logic v, input logic [3:0] d, input logic l,
                      input logic wr, output logic acc);
    logic exp_rdy;
    logic fin;
    int   n;
    exp_t e;
    nib_valid = v; nib_data = d; nib_last = l; word_ready = wr;
    #1;
    exp_rdy = !(m_nibs.size() == 7 && exp_q.size() != 0 && !wr);
    chk("frame_err", err_s, err_pend);
    chk("word_valid", val_s, exp_q.size() != 0);
    chk("nib_ready", rdy_s, exp_rdy);
    if (exp_q.size() != 0) begin
      chk("word_data", data_s, exp_q[0].data);
      chk("word_last", last_s, exp_q[0].last);
    end
    acc = v && rdy_s;
    if (exp_q.size() != 0 && wr) void'(exp_q.pop_front());
    err_pend = 1'b0;
    if (acc) begin
      m_nibs.push_back(d);
      n   = m_nibs.size();
      fin = (n == 8) && (m_widx == nw() - 1);
      err_pend = (l != fin);
      if (n == 8) begin
        e.data = 32'h0;
        for (int k = 0; k < 8; k++) e.data = e.data | (32'(m_nibs[k]) << (4 * k));
        e.last = (m_widx == nw() - 1) || l;
        exp_q.push_back(e);
        m_nibs.delete();
        if (l || fin) m_widx = 0; else m_widx++;
      end else if (l) begin
        m_nibs.delete();
        m_widx = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic send_nib(input logic [3:0] d, input logic l, input logic wr);
    logic acc;
    acc = 1'b0;
    for (int t = 0; t < 40 && !acc; t++) begin
      step(1'b1, d, l, wr, acc);
      if (!acc) stall_cnt++;
    end
    if (!acc) chk("accept_timeout", 32'(acc), 32'd1);
  endtask

  task automatic send_word(input logic [31:0] w, input logic lst, input logic wr);
    for (int k = 0; k < 8; k++) send_nib(w[4*k +: 4], lst && (k == 7), wr);
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) step(1'b0, 4'h0, 1'b0, 1'b1, acc);
  endtask

  task automatic do_reset();
    nib_valid = 1'b0; nib_last = 1'b0; nib_data = 4'h0; word_ready = 1'b1;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // ---------------- directed table (NWORDS=1) ----------------
  typedef struct {
    logic        v;
    logic [3:0]  d;
    logic        l;
    logic        wr;
    logic        ev;
    logic [31:0] ed;
    logic        el;
    logic        ee;
  } vec_t;

  vec_t tbl[10];

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] w;
    logic        l;
    sel = 1'b0; rst_n = 1'b0;
    nib_valid = 1'b0; nib_last = 1'b0; nib_data = 4'h0; word_ready = 1'b1;
    m_widx = 0; err_pend = 1'b0; stall_cnt = 0;

    // Reset values for both instances.
    @(negedge clk);
    chk("rst_ready_a", rdy_a, 1);  chk("rst_valid_a", val_a, 0);
    chk("rst_data_a", data_a, 0);  chk("rst_last_a", last_a, 0);
    chk("rst_err_a", err_a, 0);
    chk("rst_ready_b", rdy_b, 1);  chk("rst_valid_b", val_b, 0);
    chk("rst_data_b", data_b, 0);  chk("rst_last_b", last_b, 0);
    chk("rst_err_b", err_b, 0);

    // Table: nibbles 8..1, last on 1 -> 0x12345678 exactly one cycle later.
    for (int i = 0; i < 10; i++) begin
      tbl[i].v  = (i < 8);
      tbl[i].d  = (i < 8) ? 4'(8 - i) : 4'h0;
      tbl[i].l  = (i == 7);
      tbl[i].wr = 1'b1;
      tbl[i].ev = (i == 8);
      tbl[i].ed = 32'h1234_5678;
      tbl[i].el = 1'b1;
      tbl[i].ee = 1'b0;
    end
    sel = 1'b1;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      chk("tbl_valid", val_s, tbl[i].ev);
      chk("tbl_err", err_s, tbl[i].ee);
      chk("tbl_ready", rdy_s, 1);
      if (tbl[i].ev) begin
        chk("tbl_data", data_s, tbl[i].ed);
        chk("tbl_last", last_s, tbl[i].el);
      end
      nib_valid = tbl[i].v; nib_data = tbl[i].d;
      nib_last = tbl[i].l; word_ready = tbl[i].wr;
      @(negedge clk);
    end

    // NWORDS=2 back-to-back, no bubbles.
    sel = 1'b0;
    do_reset();
    stall_cnt = 0;
    send_word(32'hDEAD_BEEF, 1'b0, 1'b1);
    send_word(32'h0123_4567, 1'b1, 1'b1);
    chk("no_bubble", 32'(stall_cnt), 0);
    idle(3);

    // Backpressure: word 0 stalled while word 1 arrives.
    do_reset();
    w = 32'h3333_4444;
    send_word(32'h1111_2222, 1'b0, 1'b0);
    for (int k = 0; k < 7; k++) send_nib(w[4*k +: 4], 1'b0, 1'b0);
    step(1'b1, w[31:28], 1'b1, 1'b0, acc_d);
    chk("stall_acc0", acc_d, 0);
    step(1'b1, w[31:28], 1'b1, 1'b0, acc_d);
    chk("stall_acc1", acc_d, 0);
    step(1'b1, w[31:28], 1'b1, 1'b1, acc_d);
    chk("release_acc", acc_d, 1);
    idle(3);

    // Early nib_last on nibble 3, then clean words from counter 0.
    do_reset();
    for (int k = 0; k < 4; k++) send_nib(4'h9, k == 3, 1'b1);
    send_word(32'hCAFE_F00D, 1'b0, 1'b1);
    send_word(32'h5555_AAAA, 1'b1, 1'b1);
    idle(3);

    // Missing nib_last with NWORDS=1, then a clean frame.
    sel = 1'b1;
    do_reset();
    send_word(32'hA5A5_A5A5, 1'b0, 1'b1);
    send_word(32'h1234_5678, 1'b1, 1'b1);
    idle(3);

    // Asynchronous reset with a pending word and a live frame_err pulse.
    sel = 1'b0;
    do_reset();
    w = 32'h1234_5678;
    send_word(32'h0F0F_0F0F, 1'b0, 1'b0);
    for (int k = 0; k < 5; k++) send_nib(w[4*k +: 4], k == 4, 1'b0);
    chk("pre_rst_err", err_s, 1);
    chk("pre_rst_valid", val_s, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_valid", val_s, 0);
    chk("async_data", data_s, 0);
    chk("async_err", err_s, 0);
    chk("async_ready", rdy_s, 1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    send_word(32'h1234_5678, 1'b0, 1'b1);
    send_word(32'h9ABC_DEF0, 1'b1, 1'b1);
    idle(3);

    // Randomized traffic against the model on both instances.
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      do_reset();
      for (int c = 0; c < 800; c++) begin
        if (m_nibs.size() == 7 && m_widx == nw() - 1) l = ($urandom % 8) != 0;
        else l = ($urandom % 40) == 0;
        step(($urandom % 4) != 0, 4'($urandom), l, ($urandom % 4) != 0, acc_d);
      end
      idle(4);
      chk("drain_empty", 32'(exp_q.size()), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/nibble_assembler.md
Name: nibble_assembler

Overview:
- Receive-side counterpart of the hash nibble-order inverter.
- Accepts a hash digest streamed one 4-bit nibble per transfer in inverted order: nibble 0 of a word is its least-significant nibble.
- Reassembles each run of 8 nibbles into a 32-bit word in natural bit order, and frames NWORDS words into one digest.
- Sits between the serial/display-order nibble link and the hash compare/storage logic.

Parameters:
- NWORDS, 8: 32-bit words per digest; legal range 1..16.
- CNT_W, $clog2(NWORDS) (minimum 1): width of the word counter.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- nib_valid  input  1  upstream nibble valid
- nib_ready  output  1  block accepts a nibble this cycle
- nib_data  input  4  nibble payload
- nib_last  input  1  marks the final nibble of the digest
- word_valid  output  1  assembled word available
- word_ready  input  1  downstream accepts the word
- word_data  output  32  assembled word
- word_last  output  1  word is word NWORDS-1 of the digest
- frame_err  output  1  one-cycle pulse on a framing violation

Behaviour:
- Reset (async assert, sync release):
  - nib_ready=1, word_valid=0, word_data=0, word_last=0, frame_err=0.
  - Nibble counter=0, word counter=0, shift register=0.
- Nibble accept: occurs when nib_valid && nib_ready.
  - Shift register updates to {nib_data, sr[31:4]}.
  - After 8 accepts, the first nibble received sits in [3:0] and the k-th in [4k+3:4k].
  - This inverts the inverter exactly.
- Nibble counter 0..7 wraps; word counter 0..NWORDS-1 wraps.
- Output register: a single-entry skid with word_valid/word_ready.
  - Transfer on word_valid && word_ready.
  - word_data/word_last hold stable while word_valid && !word_ready.
- nib_ready:
  - =1 while nibble counter < 7.
  - At nibble counter == 7, nib_ready = !word_valid || word_ready, a combinational path from word_ready.
  - A stalled 8th nibble is never dropped or overwritten.
- Completion (8th nibble accepted):
  - On the next edge, word_data = {nib_data, sr[31:4]}, word_valid=1.
  - word_last = (word counter == NWORDS-1).
  - Latency: 1 cycle from 8th-nibble accept to word_valid.
- Simultaneous drain and load: the new word replaces the old in the same cycle; word_valid stays 1.
- Throughput: sustained 1 nibble/cycle with word_ready tied high, no bubbles.
- Framing (evaluated on each accepted nibble):
  - nib_last on any nibble other than nibble 7 of word NWORDS-1:
    - frame_err pulses next cycle.
    - The partial word is discarded; nibble and word counters reset to 0.
    - No word is emitted for that partial word.
  - nib_last on nibble 7 of a word that is not word NWORDS-1:
    - The word is emitted with word_last=1.
    - frame_err pulses; counters reset to 0.
  - Nibble 7 of word NWORDS-1 without nib_last:
    - The word is emitted with word_last=1.
    - frame_err pulses; counters reset to 0 (resync to the next digest).
  - Correct termination: word_last=1 with no error; counters reset to 0.
- Reset mid-operation: partial word and any pending output are lost; all state returns to reset values immediately.
- frame_err is independent of word_ready; it is never held.

Decomposition:
- Shared package hash_pkg holds:
  - NIB_W=4, WORD_W=32, NIBS_PER_WORD=8 constants.
  - A typedef nibble_t (logic [3:0]) and hash_word_t (logic [31:0]).
- One sub-module, nibble_word_reg, is the 32-bit valid/ready output register holding word_data/word_last.
- All counting and framing logic stays in the top module.

Test Plan:
- NWORDS=1, nibbles 8,7,6,5,4,3,2,1 (last on 1), word_ready=1:
  - word_data=0x12345678, word_last=1, frame_err=0.
  - word_valid exactly 1 cycle after the 8th accept.
- NWORDS=2, 16 back-to-back nibbles encoding 0xDEADBEEF then 0x01234567, nib_valid held high:
  - nib_ready never drops.
  - Words emitted in order; word_last only on 0x01234567.
- Backpressure: hold word_ready=0 while word 0 is valid and 8 more nibbles arrive:
  - nib_ready=0 at nibble 7 of word 1; word 0 data stable.
  - On word_ready=1, word 1 loads in the same cycle with no loss.
- Early nib_last on nibble 3 of word 0:
  - frame_err one-cycle pulse; no word_valid.
  - The next 8 nibbles of 0xCAFEF00D assemble correctly from counter 0.
- Missing nib_last, NWORDS=1, nibbles of 0xA5A5A5A5 without last:
  - Word emitted with word_last=1 and a frame_err pulse.
  - The following frame assembles cleanly.
- Assert rst_n low asynchronously after 5 nibbles with word_valid=1 pending:
  - word_valid, word_data and frame_err drop to 0 immediately, and nib_ready=1.
  - After release, a full frame of 0x12345678 is correct.
